axis_loopback_tester: RTL and testbench



---
 rtl/axis_loopback_tester.sv | 189 ++++++++++++++++++
 tb/tb_axis_loopback_tester.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_loopback_tester.sv
// AXI-Stream loopback tester: sends NUM_PKTS counting packets, checks each returned packet, reports pass/fail.
// Optional macro AXIS_TESTER_BACKPRESSURE_EN adds pseudo-random s00 backpressure during RECV.
module axis_loopback_tester #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_START_COUNT      = 32,
  parameter int PKT_LEN            = 80,
  parameter int NUM_PKTS           = 4,
  parameter int TIMEOUT            = 1024
) (
  input  logic                            axis_aclk,
  input  logic                            axis_aresetn,
  input  logic                            start,
  output logic                            m00_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tlast,
  input  logic                            m00_axis_tready,
  input  logic                            s00_axis_tvalid,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tlast,
  output logic                            s00_axis_tready,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            timeout,
  output logic [15:0]                     err_count,
  output logic [7:0]                      pkt_count,
  output logic [2:0]                      state_dbg
);

  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int SW = C_AXIS_TDATA_WIDTH / 8;
  localparam logic [15:0] PKT_LAST   = 16'(PKT_LEN - 1);
  localparam logic [7:0]  NP         = 8'(NUM_PKTS);
  localparam logic [31:0] START_LAST = (C_START_COUNT == 0) ? 32'd0 : 32'(C_START_COUNT - 1);
  localparam logic [31:0] WD_LAST    = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    SEND       = 3'd2,
    RECV       = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]   rst_sync;
  logic         rst_n;
  logic [31:0]  ws_cnt;
  logic [31:0]  wd_cnt;
  logic [15:0]  tx_idx;
  logic [15:0]  rx_idx;
  logic [W-1:0] pkt_base;
  logic [W-1:0] rx_exp;
  logic         rx_active;
  logic         tx_fire, tx_last;
  logic         rx_fire, rx_last_idx, rx_bad, rx_end, run_done;
  logic         wd_expire, run_start;
  logic         unused_strb;

  // Reset asserts asynchronously and releases two edges later, so state is IDLE at the first live edge.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) rst_sync <= 2'b00;
    else               rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Handshake: a beat transfers on the rising edge where valid && ready; the sender holds
  // data/last stable while valid is high and ready is low. m00 is a sender, s00 a receiver.
  assign tx_fire     = m00_axis_tvalid && m00_axis_tready;
  assign tx_last     = (tx_idx == PKT_LAST);
  assign rx_fire     = rx_active && s00_axis_tvalid && s00_axis_tready;
  assign rx_last_idx = (rx_idx == PKT_LAST);
  assign rx_exp      = pkt_base + W'(rx_idx);
  assign rx_bad      = (s00_axis_tdata != rx_exp) || (s00_axis_tlast != rx_last_idx);
  assign rx_end      = rx_fire && (s00_axis_tlast || rx_last_idx);
  assign run_done    = rx_end && (8'(pkt_count + 8'd1) == NP);
  assign wd_expire   = rx_active && !rx_fire && (wd_cnt == WD_LAST);
  assign run_start   = start && ((state == IDLE) || (state == DONE));
  assign unused_strb = ^s00_axis_tstrb;

  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    busy            = 1'b0;
    done            = 1'b0;
    m00_axis_tvalid = 1'b0;
    rx_active       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = WAIT_START;
      end
      WAIT_START: begin
        busy = 1'b1;
        if ((C_START_COUNT == 0) || (ws_cnt == START_LAST)) state_nxt = SEND;
      end
      SEND: begin
        busy            = 1'b1;
        m00_axis_tvalid = 1'b1;
        if (tx_fire && tx_last) state_nxt = RECV;
      end
      RECV: begin
        busy      = 1'b1;
        rx_active = 1'b1;
        if (rx_end)         state_nxt = run_done ? DONE : SEND;
        else if (wd_expire) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = WAIT_START;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      ws_cnt    <= '0;
      wd_cnt    <= '0;
      tx_idx    <= '0;
      rx_idx    <= '0;
      pkt_base  <= '0;
      err_count <= '0;
      pkt_count <= '0;
      timeout   <= 1'b0;
    end else if (run_start) begin
      ws_cnt    <= '0;
      wd_cnt    <= '0;
      tx_idx    <= '0;
      rx_idx    <= '0;
      pkt_base  <= '0;
      err_count <= '0;
      pkt_count <= '0;
      timeout   <= 1'b0;
    end else begin
      if (state == WAIT_START) ws_cnt <= ws_cnt + 32'd1;
      if (tx_fire) tx_idx <= tx_last ? 16'd0 : tx_idx + 16'd1;
      // Watchdog measures RECV cycles since entry or since the last accepted beat.
      if (tx_fire && tx_last) wd_cnt <= '0;
      else if (rx_active)     wd_cnt <= rx_fire ? 32'd0 : wd_cnt + 32'd1;
      if (rx_fire) begin
        if (rx_bad && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        rx_idx <= rx_end ? 16'd0 : rx_idx + 16'd1;
      end
      if (rx_end) begin
        pkt_count <= pkt_count + 8'd1;
        pkt_base  <= pkt_base + W'(PKT_LEN);
      end
      if (wd_expire) timeout <= 1'b1;
    end
  end

  assign m00_axis_tdata = pkt_base + W'(tx_idx);
  assign m00_axis_tstrb = {SW{m00_axis_tvalid}};
  assign m00_axis_tlast = m00_axis_tvalid && tx_last;
  assign pass           = done && (err_count == 16'd0) && !timeout;
  assign state_dbg      = state;

`ifdef AXIS_TESTER_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic [1:0]  low_run;
  logic        bp_ready;

  // Ready follows the LFSR but is never held low for more than three cycles in a row.
  assign bp_ready = lfsr[0] || (low_run == 2'd3);

  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= 16'hACE1;
      low_run <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (rx_active && !bp_ready) low_run <= low_run + 2'd1;
      else                        low_run <= '0;
    end
  end

  assign s00_axis_tready = rx_active && bp_ready;
`else
  assign s00_axis_tready = rx_active;
`endif

endmodule

// File: tb/tb_axis_loopback_tester.sv
// Directed bench for axis_loopback_tester: a loopback responder returns m00 beats on s00 with optional faults.
module tb_axis_loopback_tester;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         m00_axis_tvalid;
  logic [W-1:0] m00_axis_tdata;
  logic [3:0]   m00_axis_tstrb;
  logic         m00_axis_tlast;
  logic         m00_axis_tready = 1'b1;
  logic         s00_axis_tvalid = 1'b0;
  logic [W-1:0] s00_axis_tdata = '0;
  logic [3:0]   s00_axis_tstrb = 4'hF;
  logic         s00_axis_tlast = 1'b0;
  logic         s00_axis_tready;
  logic         busy, done, pass, timeout;
  logic [15:0]  err_count;
  logic [7:0]   pkt_count;
  logic [2:0]   state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W:0] exp_q[$];
  logic [W:0] lb_q[$];
  logic [W:0] exp_beat, beat;
  logic [W-1:0] hold_d;
  logic         hold_l;

  logic stall = 1'b0;
  logic no_return = 1'b0;
  int corrupt_pkt = -1, corrupt_beat = -1, early_pkt = -1, early_beat = -1;
  int rx_pkt = 0, rx_beat = 0, tx_cnt = 0, rx_cnt = 0;
  int first_valid_cyc = -1, last_tlast_cyc = -1, start_cyc = 0, done_cyc = 0;

  axis_loopback_tester dut (
    .axis_aclk       (clk),
    .axis_aresetn    (rst_n),
    .start           (start),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tready (m00_axis_tready),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tready (s00_axis_tready),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timeout         (timeout),
    .err_count       (err_count),
    .pkt_count       (pkt_count),
    .state_dbg       (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loopback responder: decides at each falling edge what transfers on the next rising edge.
  initial forever begin
    @(negedge clk);
    m00_axis_tready = !stall;
    if (first_valid_cyc < 0 && m00_axis_tvalid) first_valid_cyc = cyc;
    if (m00_axis_tvalid && m00_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("m00_unexpected_beat", {m00_axis_tlast, m00_axis_tdata}, 64'h1_FFFF_FFFF);
      end else begin
        exp_beat = exp_q.pop_front();
        check("m00_beat", {m00_axis_tlast, m00_axis_tdata}, exp_beat);
      end
      check("m00_tstrb", m00_axis_tstrb, 4'hF);
      check("s00_ready_in_send", s00_axis_tready, 0);
      if (m00_axis_tlast) last_tlast_cyc = cyc + 1;
      if (!no_return) lb_q.push_back({m00_axis_tlast, m00_axis_tdata});
      tx_cnt++;
    end
    if (lb_q.size() > 0) begin
      beat = lb_q[0];
      if (rx_pkt == corrupt_pkt && rx_beat == corrupt_beat) beat[W-1:0] = 32'h0000_DEAD;
      if (rx_pkt == early_pkt && rx_beat == early_beat) beat[W] = 1'b1;
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = beat[W-1:0];
      s00_axis_tlast  = beat[W];
      if (s00_axis_tready) begin
        void'(lb_q.pop_front());
        rx_cnt++;
        if (rx_pkt == early_pkt && rx_beat == early_beat) lb_q.delete();
        if (beat[W]) begin
          rx_pkt++;
          rx_beat = 0;
        end else begin
          rx_beat++;
        end
      end
    end else begin
      s00_axis_tvalid = 1'b0;
      s00_axis_tdata  = '0;
      s00_axis_tlast  = 1'b0;
    end
  end

  task automatic fill_run();
    exp_q.delete();
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 80; i++)
        exp_q.push_back({(i == 79) ? 1'b1 : 1'b0, 32'(p * 80 + i)});
  endtask

  task automatic do_start();
    @(posedge clk);
    #2;
    lb_q.delete();
    fill_run();
    rx_pkt = 0;
    rx_beat = 0;
    tx_cnt = 0;
    rx_cnt = 0;
    first_valid_cyc = -1;
    start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin
      @(posedge clk);
      #2;
      k++;
    end
    done_cyc = cyc;
    check({tag, "_done"}, done, 1);
  endtask

  task automatic check_result(input string tag, input int err, input int ps, input int pkts, input int tmo);
    check({tag, "_err_count"}, err_count, err);
    check({tag, "_pass"}, pass, ps);
    check({tag, "_pkt_count"}, pkt_count, pkts);
    check({tag, "_timeout"}, timeout, tmo);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (tx_cnt < n && k < 500) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("tx_reached", tx_cnt, n);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_tvalid", m00_axis_tvalid, 0);
    check("rst_tdata", m00_axis_tdata, 0);
    check("rst_s00_ready", s00_axis_tready, 0);
    check("rst_flags", {busy, done, pass, timeout}, 0);
    check("rst_counts", {err_count, pkt_count}, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("idle_busy", busy, 0);

    // Ideal loopback, with a stray start during WAIT_START that must be ignored
    do_start();
    repeat (5) @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("ideal", 3000);
    check("ideal_latency", first_valid_cyc - start_cyc, 32);
    check("ideal_tx_beats", tx_cnt, 320);
    check("ideal_rx_beats", rx_cnt, 320);
    check("ideal_exp_left", exp_q.size(), 0);
    check_result("ideal", 0, 1, 4, 0);

    // Sink stall of 5 cycles in the middle of packet 0
    do_start();
    wait_tx(30);
    stall = 1'b1;
    hold_d = m00_axis_tdata;
    hold_l = m00_axis_tlast;
    check("stall_first_tdata", hold_d, 30);
    repeat (5) begin
      @(posedge clk);
      #2;
      check("stall_tvalid", m00_axis_tvalid, 1);
      check("stall_tdata", m00_axis_tdata, 30);
      check("stall_tlast", m00_axis_tlast, hold_l);
    end
    stall = 1'b0;
    wait_done("stall", 3000);
    check("stall_exp_left", exp_q.size(), 0);
    check_result("stall", 0, 1, 4, 0);

    // Beat 7 of packet 0 corrupted to 0xDEAD
    corrupt_pkt = 0;
    corrupt_beat = 7;
    do_start();
    wait_done("corrupt", 3000);
    check_result("corrupt", 1, 0, 4, 0);
    corrupt_pkt = -1;
    corrupt_beat = -1;

    // Packet 1 returned with tlast at beat 40
    early_pkt = 1;
    early_beat = 40;
    do_start();
    wait_done("early", 3000);
    check("early_exp_left", exp_q.size(), 0);
    check("early_rx_beats", rx_cnt, 281);
    check_result("early", 1, 0, 4, 0);
    early_pkt = -1;
    early_beat = -1;

    // No return data: watchdog fires 1024 cycles after RECV entry
    no_return = 1'b1;
    do_start();
    wait_done("tmo", 3000);
    check("tmo_delay", done_cyc - last_tlast_cyc, 1024);
    check("tmo_tx_beats", tx_cnt, 80);
    check_result("tmo", 0, 0, 0, 1);
    no_return = 1'b0;

    // Restart from DONE clears the sticky timeout
    do_start();
    wait_done("rerun", 3000);
    check("rerun_exp_left", exp_q.size(), 0);
    check_result("rerun", 0, 1, 4, 0);

    // Reset during SEND beat 10, then replay from packet 0
    do_start();
    wait_tx(10);
    check("pre_rst_tdata", m00_axis_tdata, 10);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", m00_axis_tvalid, 0);
    check("midrst_tdata", m00_axis_tdata, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", state_dbg, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    do_start();
    wait_done("replay", 3000);
    check("replay_latency", first_valid_cyc - start_cyc, 32);
    check("replay_tx_beats", tx_cnt, 320);
    check("replay_exp_left", exp_q.size(), 0);
    check_result("replay", 0, 1, 4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
